// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the LSU (port 0)
// and a DMA/debug requester (port 1), with bounded burst locking and address checking.

// Per-port response register: one-cycle-latency rvalid/rdata/err.
module dmem_arb_rsp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        we,
  input  logic        err,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rerr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rerr   <= 1'b0;
    end else begin
      rvalid <= gnt;
      if (gnt) begin
        rerr  <= err;
        rdata <= (!we && !err) ? mem_rdata : '0;
      end
    end
  end
endmodule

module dmem_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int NP = 2;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

  logic [NP-1:0]        req, we, lock, gnt, rvalid, rerr;
  logic [NP-1:0][31:0]  addr, wdata, rdata;

  logic          last_gnt, owner_locked;
  logic [CW-1:0] burst_cnt;

  logic        win, gnt_any, err;
  logic [31:0] w_addr;

  // Requests are gated by reset so nothing is granted while it is asserted.
  assign req   = {p1_req, p0_req} & {NP{rst_n}};
  assign we    = {p1_we, p0_we};
  assign lock  = {p1_lock, p0_lock};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  always_comb begin
    win = 1'b0;
    if (req == 2'b11)
      win = (owner_locked && burst_cnt < CW'(MAX_BURST)) ? last_gnt : ~last_gnt;
    else
      win = req[1];
  end

  assign gnt_any = |req;
  assign gnt[0]  = gnt_any && !win;
  assign gnt[1]  = gnt_any && win;
  assign w_addr  = addr[win];
  assign err     = (w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIM);

  assign mem_we    = gnt_any && we[win] && !err;
  assign mem_addr  = gnt_any ? w_addr : '0;
  assign mem_wdata = gnt_any ? wdata[win] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt     <= 1'b1;
      owner_locked <= 1'b0;
      burst_cnt    <= '0;
    end else if (gnt_any) begin
      last_gnt     <= win;
      owner_locked <= lock[win];
      // Count continues through a locked run even when uncontested, saturating.
      if (win == last_gnt && owner_locked)
        burst_cnt <= (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
      else
        burst_cnt <= CW'(1);
    end
  end

  for (genvar n = 0; n < NP; n++) begin : g_rsp
    dmem_arb_rsp u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt[n]),
      .we        (we[n]),
      .err       (err),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid[n]),
      .rdata     (rdata[n]),
      .rerr      (rerr[n])
    );
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p0_err    = rerr[0];
  assign p1_err    = rerr[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioral 1024x32 memory behind it.
module tb_dmem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p0_lock = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [1024];
  int total = 0, bad = 0;

  dmem_arbiter #(.MEM_WORDS(1024), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_p0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
    p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; p0_lock = l;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
    p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; p1_lock = l;
  endtask

  task automatic do_reset();
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_p0(1, 1, 32'h10, 32'h1234_5678, 0); set_p1(1, 0, 32'h14, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if ({p0_gnt, p1_gnt, mem_we} !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b exp=000", {p0_gnt, p1_gnt, mem_we}); end
      total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL rst_mem got=%h/%h exp=0", mem_addr, mem_wdata); end
      total++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0) begin bad++; $display("FAIL rst_rsp got=%b exp=0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
      total++; if ({p0_rdata, p1_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", p0_rdata, p1_rdata); end
      step();
    end
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    rst_n = 1'b1; #1;
  endtask

  task automatic test_write_read();
    set_p0(1, 1, 32'h10, 32'hDEAD_BEEF, 0); #1;
    total++; if ({p0_gnt, p1_gnt, mem_we} !== 3'b101) begin bad++; $display("FAIL wr_gnt got=%b exp=101", {p0_gnt, p1_gnt, mem_we}); end
    total++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_bus got=%h/%h exp=10/deadbeef", mem_addr, mem_wdata); end
    step();
    total++; if ({p0_rvalid, p0_err} !== 2'b10 || p0_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got=%b/%h exp=10/0", {p0_rvalid, p0_err}, p0_rdata); end
    set_p0(1, 0, 32'h10, 0, 0); #1;
    total++; if ({p0_gnt, mem_we} !== 2'b10) begin bad++; $display("FAIL rd_gnt got=%b exp=10", {p0_gnt, mem_we}); end
    step();
    set_p0(0, 0, 0, 0, 0);
    total++; if ({p0_rvalid, p0_err} !== 2'b10 || p0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rsp got=%b/%h exp=10/deadbeef", {p0_rvalid, p0_err}, p0_rdata); end
    step();
    total++; if (p0_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop got=%b exp=0", p0_rvalid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_p0(1, 0, 32'h10, 0, 0); set_p1(1, 0, 32'h14, 0, 0);
    for (int c = 0; c < 6; c++) begin
      logic [1:0] eg;
      eg = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      total++; if ({p1_gnt, p0_gnt} !== eg) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, {p1_gnt, p0_gnt}, eg); end
      step();
      total++; if ({p1_rvalid, p0_rvalid} !== eg) begin bad++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, {p1_rvalid, p0_rvalid}, eg); end
      if (eg[0]) begin
        total++; if (p0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rr_rdata0 c=%0d got=%h exp=deadbeef", c, p0_rdata); end
      end else begin
        total++; if (p1_rdata !== 32'h1414_1414) begin bad++; $display("FAIL rr_rdata1 c=%0d got=%h exp=14141414", c, p1_rdata); end
      end
    end
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_burst();
    logic [9:0] exp_p1;
    exp_p1 = 10'b01_1110_1111;  // bit c: p1 wins cycle c
    do_reset();
    set_p1(1, 0, 32'h14, 0, 1);
    for (int c = 0; c < 10; c++) begin
      p0_req = (c > 0); p0_addr = 32'h10;
      #1;
      total++; if ({p1_gnt, p0_gnt} !== {exp_p1[c], !exp_p1[c]}) begin bad++; $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, {p1_gnt, p0_gnt}, {exp_p1[c], !exp_p1[c]}); end
      step();
      total++; if (p1_rvalid !== exp_p1[c]) begin bad++; $display("FAIL burst_rvalid c=%0d got=%b exp=%b", c, p1_rvalid, exp_p1[c]); end
    end
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_errors();
    logic [31:0] ba [2];
    logic [31:0] ra [3];
    logic [31:0] rv [3];
    ba[0] = 32'h13; ba[1] = 32'h1000;
    ra[0] = 32'h10; ra[1] = 32'hFFC; ra[2] = 32'h0;
    rv[0] = 32'hDEAD_BEEF; rv[1] = 32'h0FFC_0FFC; rv[2] = 32'h0000_C0DE;
    for (int i = 0; i < 2; i++) begin
      set_p0(1, 1, ba[i], 32'hBAD0_BAD0, 0); #1;
      total++; if ({p0_gnt, mem_we} !== 2'b10) begin bad++; $display("FAIL err_we i=%0d got=%b exp=10", i, {p0_gnt, mem_we}); end
      step();
      total++; if ({p0_rvalid, p0_err} !== 2'b11 || p0_rdata !== 32'h0) begin bad++; $display("FAIL err_rsp i=%0d got=%b/%h exp=11/0", i, {p0_rvalid, p0_err}, p0_rdata); end
    end
    for (int i = 0; i < 3; i++) begin
      set_p0(1, 0, ra[i], 0, 0); step();
      total++; if ({p0_rvalid, p0_err} !== 2'b10 || p0_rdata !== rv[i]) begin bad++; $display("FAIL err_readback i=%0d got=%b/%h exp=10/%h", i, {p0_rvalid, p0_err}, p0_rdata, rv[i]); end
    end
    set_p0(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_same_addr();
    do_reset();
    set_p0(1, 1, 32'h20, 32'hA5A5_A5A5, 0); set_p1(1, 0, 32'h20, 0, 0); #1;
    total++; if ({p1_gnt, p0_gnt, mem_we} !== 3'b011) begin bad++; $display("FAIL same_first got=%b exp=011", {p1_gnt, p0_gnt, mem_we}); end
    step();
    set_p0(0, 0, 0, 0, 0); #1;
    total++; if ({p1_gnt, p0_gnt, mem_we} !== 3'b100) begin bad++; $display("FAIL same_second got=%b exp=100", {p1_gnt, p0_gnt, mem_we}); end
    step();
    set_p1(0, 0, 0, 0, 0);
    total++; if ({p1_rvalid, p1_err} !== 2'b10 || p1_rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL same_rdata got=%b/%h exp=10/a5a5a5a5", {p1_rvalid, p1_err}, p1_rdata); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_p1(1, 1, 32'h30, 32'h1111_1111, 1); #1;
    total++; if ({p1_gnt, mem_we} !== 2'b11) begin bad++; $display("FAIL rb_first got=%b exp=11", {p1_gnt, mem_we}); end
    step();
    set_p1(1, 1, 32'h34, 32'h2222_2222, 1); #1;
    total++; if ({p1_gnt, mem_we, p1_rvalid} !== 3'b111) begin bad++; $display("FAIL rb_second got=%b exp=111", {p1_gnt, mem_we, p1_rvalid}); end
    rst_n = 1'b0; #1;
    total++; if ({p1_gnt, mem_we, p1_rvalid} !== 3'b000 || mem_addr !== 32'h0) begin bad++; $display("FAIL rb_async got=%b/%h exp=000/0", {p1_gnt, mem_we, p1_rvalid}, mem_addr); end
    step();
    total++; if (p1_rvalid !== 1'b0) begin bad++; $display("FAIL rb_no_rsp got=%b exp=0", p1_rvalid); end
    total++; if (mem[12] !== 32'h1111_1111 || mem[13] !== 32'h3434_3434) begin bad++; $display("FAIL rb_mem got=%h/%h exp=11111111/34343434", mem[12], mem[13]); end
    set_p1(0, 0, 0, 0, 0); rst_n = 1'b1; #1;
    set_p0(1, 0, 32'h10, 0, 0); set_p1(1, 0, 32'h14, 0, 0); #1;
    total++; if ({p1_gnt, p0_gnt} !== 2'b01) begin bad++; $display("FAIL rb_tie got=%b exp=01", {p1_gnt, p0_gnt}); end
    step();
    set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
    total++; if ({p1_rvalid, p0_rvalid} !== 2'b01) begin bad++; $display("FAIL rb_tie_rsp got=%b exp=01", {p1_rvalid, p0_rvalid}); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_C0DE; mem[5] = 32'h1414_1414; mem[12] = 32'h3030_3030;
    mem[13] = 32'h3434_3434; mem[1023] = 32'h0FFC_0FFC;
    test_reset();
    test_write_read();
    test_round_robin();
    test_burst();
    test_errors();
    test_same_addr();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, 1024x32 data memory between the core load/store unit (port 0) and a DMA/debug requester (port 1). It grants at most one access per cycle using round-robin, supports bounded bus locking for bursts, and checks every address for alignment and range. It returns a registered, one-cycle-latency response for every granted access. It sits between the requesters and the data memory, and drives the memory's write enable, address, and write data.

## Interface
- MEM_WORDS, 1024: memory depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1
- MAX_BURST, 4: maximum consecutive grants to a locking port while the other port is waiting
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- pN_req  in  1  port N (N=0,1) request; held stable with we/addr/wdata/lock until granted
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  32  byte address
- pN_wdata  in  32  write data
- pN_lock  in  1  request to keep ownership on the next cycle (burst)
- pN_gnt  out  1  combinational grant; the access is performed in this cycle
- pN_rvalid  out  1  response valid, registered, one cycle after pN_gnt
- pN_rdata  out  32  registered read data; 0 for writes and errors
- pN_err  out  1  registered; qualifies pN_rvalid; misaligned or out-of-range access
- mem_we  out  1  to memory write enable
- mem_addr  out  32  to memory address
- mem_wdata  out  32  to memory write data
- mem_rdata  in  32  combinational read data from memory

## Operation
- State:
  - last_gnt (1 bit; reset 1, so port 0 wins the first tie)
  - owner_locked (1 bit; reset 0)
  - burst_cnt (clog2(MAX_BURST+1) bits; reset 0)
  - rsp registers per port
- Arbitration, evaluated each cycle while rst_n=1:
  - If only one port requests, that port is granted.
  - If both request and owner_locked=1 and burst_cnt < MAX_BURST, the previous owner (last_gnt) is granted.
  - Otherwise, when both request, the port != last_gnt is granted.
- At most one pN_gnt is high. No request means no grant, mem_we=0 and mem_addr=0.
- On a grant:
  - last_gnt <= winner.
  - owner_locked <= winner's lock.
  - burst_cnt <= (winner == previous last_gnt && owner_locked) ? burst_cnt+1 : 1.
- Error check: err = (addr[1:0] != 0) || (addr >= 4*MEM_WORDS). On an error, mem_we is forced to 0; the grant is still consumed.
- mem_addr and mem_wdata carry the winner's fields. mem_we = winner.we && !err.
- Response, next edge after the grant:
  - pN_rvalid <= 1.
  - pN_err <= err.
  - pN_rdata <= (!we && !err) ? mem_rdata : 0.
  - When there is no grant to port N, pN_rvalid <= 0; rdata and err hold their values.
- The lock is ignored while the other port is not requesting; the burst counter still counts and saturates at MAX_BURST.
- When MAX_BURST is reached with the other port waiting, the other port is granted; owner_locked is then taken from the new winner.

## Timing
- Grant: same cycle as the request (combinational from req and state).
- Write: the memory updates at the rising edge that ends the grant cycle.
- Read/response: pN_rvalid is high exactly in the cycle after pN_gnt. Throughput is 1 access per cycle total.
- Back-to-back grants to one port give consecutive rvalid pulses.
- Reset, asynchronous:
  - All outputs are low/zero immediately: pN_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, pN_rvalid=0, pN_rdata=0, pN_err=0.
  - Gnt and mem_we are gated by rst_n.
  - An access granted in the cycle that reset asserts produces no response.
  - After release, the first tie goes to port 0.
- Read-after-write to the same address on consecutive grants returns the new data.
- A same-cycle request from both ports to the same address: only the winner accesses memory. The loser is granted on a later cycle and sees the updated contents.

## Test plan
- Reset, then p0 writes 0xDEADBEEF to 0x10, then p0 reads 0x10 -> p0_gnt same cycle each time; on the read, p0_rvalid=1 one cycle later with p0_rdata=0xDEADBEEF and p0_err=0.
- Both ports read continuously with lock=0 -> grants alternate p0,p1,p0,p1...; the first grant after reset goes to p0; exactly one gnt per cycle.
- p1 locks with MAX_BURST=4 while p0 requests continuously -> p1 is granted 4 consecutive cycles, then p0 once, then p1 resumes.
- p0 writes to 0x13 (misaligned) and to 0x1000 (out of range) -> mem_we=0 both cycles; p0_rvalid=1 with p0_err=1 and p0_rdata=0; memory is unchanged (read back of 0x10/0xFFC shows old data).
- Same cycle: p0 writes 0xA5A5A5A5 to 0x20 and p1 reads 0x20, with last_gnt=1 -> p0 is granted first; p1 is granted next cycle and its rdata=0xA5A5A5A5.
- Assert rst_n=0 during a granted p1 write mid-burst -> gnt and mem_we drop immediately; no p1_rvalid follows; after release the state is cleared and a tie grants p0.
